// File: rtl/led_matrix_scan_pkg.sv
// Shared definitions for the LED matrix scanner.
//   - scan_state_e : row-scan FSM states
//   - ROWS_DEF / COLS_DEF : default matrix geometry
//   - WORD_W_DEF / word_width() : width of one shifted row word (red + blue)
package led_pkg;

  localparam int unsigned ROWS_DEF   = 8;
  localparam int unsigned COLS_DEF   = 10;
  localparam int unsigned WORD_W_DEF = 2 * COLS_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_ROWDATA,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY,
    ST_NEXT
  } scan_state_e;

  function automatic int unsigned word_width(input int unsigned cols);
    return 2 * cols;
  endfunction

endpackage

// File: rtl/led_matrix_scan_serial_shift_tx.sv
// MSB-first serial transmitter for one matrix row word.
//   clk, rst_n : system clock, asynchronous active-low reset
//   start      : one-cycle pulse; loads word, transmission begins next cycle
//   word       : WIDTH-bit row word, MSB sent first
//   sclk       : serial clock; low CLK_DIV cycles (data setup) then high CLK_DIV cycles
//   sdata      : serial data, holds its last value when idle
//   done       : high in the final cycle of the last bit (sclk returns low after it)
module serial_shift_tx
  import led_pkg::*;
#(
  parameter int unsigned WIDTH   = WORD_W_DEF,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] word,
  output logic             sclk,
  output logic             sdata,
  output logic             done
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;

  logic             busy_q,  busy_d;
  logic             sclk_q,  sclk_d;
  logic             sdata_q, sdata_d;
  logic [WIDTH-1:0] sr_q,    sr_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic [DIV_W-1:0] div_q,   div_d;

  // sclk_q doubles as the half-period phase: low = setup, high = hold.
  always_comb begin
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    div_d   = div_q;
    done    = 1'b0;
    if (start) begin
      busy_d  = 1'b1;
      sclk_d  = 1'b0;
      sdata_d = word[WIDTH-1];
      sr_d    = word << 1;
      bit_d   = '0;
      div_d   = '0;
    end else if (busy_q) begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (bit_q == BIT_W'(WIDTH - 1)) begin
            busy_d = 1'b0;
            done   = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            sdata_d = sr_q[WIDTH-1];
            sr_d    = sr_q << 1;
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

  assign sclk  = sclk_q;
  assign sdata = sdata_q;

endmodule

// File: rtl/led_matrix_scan.sv
// Two-colour LED matrix row scanner fed by the song loader's note stream.
// Each frame snapshots the note window once, then scans every row through
// shift -> latch -> display dwell.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   note_R, note_B : red / blue note bits, bit c drives column c
//   offset         : pixel row where the current notes are drawn
//   finish         : song-end pulse; the next frame is blanked to the judge line
//   mtx_sclk/mtx_sdata/mtx_latch/mtx_oe_n/mtx_row : matrix driver interface
//   frame_done     : one-cycle pulse after the last row's dwell
module led_matrix_scan
  import led_pkg::*;
#(
  parameter int unsigned ROWS       = ROWS_DEF,
  parameter int unsigned COLS       = COLS_DEF,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DWELL      = 2000,
  parameter int unsigned SHOW_JUDGE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COLS-1:0]         note_R,
  input  logic [COLS-1:0]         note_B,
  input  logic [2:0]              offset,
  input  logic                    finish,
  output logic                    mtx_sclk,
  output logic                    mtx_sdata,
  output logic                    mtx_latch,
  output logic                    mtx_oe_n,
  output logic [$clog2(ROWS)-1:0] mtx_row,
  output logic                    frame_done
);

  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned WORD_W = word_width(COLS);
  localparam int unsigned CNT_W  = $clog2((DWELL > CLK_DIV) ? DWELL : CLK_DIV) + 1;

  scan_state_e       state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  mtx_row_q, mtx_row_d;
  logic [COLS-1:0]   note_r_s_q, note_r_s_d;
  logic [COLS-1:0]   note_b_s_q, note_b_s_d;
  logic [2:0]        offset_s_q, offset_s_d;
  logic              blank_q, blank_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              latch_q, latch_d;
  logic              oe_n_q, oe_n_d;
  logic              frame_done_q, frame_done_d;

  logic [WORD_W-1:0] row_word;
  logic              on_note_row;
  logic              judge_row;
  logic              last_row;
  logic              tx_start;
  logic              tx_done;

  assign last_row    = (32'(row_q) == ROWS - 1);
  assign on_note_row = (32'(offset_s_q) == 32'(row_q));
  assign judge_row   = (SHOW_JUDGE != 0) && last_row;

  // Red field occupies the upper COLS bits so column COLS-1 red is sent first.
  always_comb begin
    row_word = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      row_word[COLS + c] = (on_note_row && note_r_s_q[c]) || judge_row;
      row_word[c]        = (on_note_row && note_b_s_q[c]) || judge_row;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    mtx_row_d  = mtx_row_q;
    note_r_s_d = note_r_s_q;
    note_b_s_d = note_b_s_q;
    offset_s_d = offset_s_q;
    cnt_d      = cnt_q;
    tx_start   = 1'b0;
    // A finish pulse always arms the blank flag; SNAP only clears a flag that
    // was already set before it, so a coincident pulse blanks the next frame.
    blank_d    = blank_q | finish;

    unique case (state_q)
      ST_IDLE: state_d = ST_SNAP;
      ST_SNAP: begin
        if (blank_q) begin
          note_r_s_d = '0;
          note_b_s_d = '0;
          offset_s_d = '0;
          blank_d    = finish;
        end else begin
          note_r_s_d = note_R;
          note_b_s_d = note_B;
          offset_s_d = offset;
        end
        state_d = ST_ROWDATA;
      end
      ST_ROWDATA: begin
        tx_start = 1'b1;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tx_done) begin
          state_d   = ST_LATCH;
          mtx_row_d = row_q;
          cnt_d     = '0;
        end
      end
      ST_LATCH: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          state_d = ST_DISPLAY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DISPLAY: begin
        if (cnt_q == CNT_W'(DWELL - 1)) begin
          state_d = ST_NEXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_NEXT: begin
        if (last_row) begin
          row_d   = '0;
          state_d = ST_SNAP;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = ST_ROWDATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    latch_d      = (state_d == ST_LATCH);
    oe_n_d       = (state_d != ST_DISPLAY);
    frame_done_d = (state_d == ST_NEXT) && last_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      mtx_row_q    <= '0;
      note_r_s_q   <= '0;
      note_b_s_q   <= '0;
      offset_s_q   <= '0;
      blank_q      <= 1'b0;
      cnt_q        <= '0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      mtx_row_q    <= mtx_row_d;
      note_r_s_q   <= note_r_s_d;
      note_b_s_q   <= note_b_s_d;
      offset_s_q   <= offset_s_d;
      blank_q      <= blank_d;
      cnt_q        <= cnt_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  serial_shift_tx #(
    .WIDTH   (WORD_W),
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .word  (row_word),
    .sclk  (mtx_sclk),
    .sdata (mtx_sdata),
    .done  (tx_done)
  );

  assign mtx_latch  = latch_q;
  assign mtx_oe_n   = oe_n_q;
  assign mtx_row    = mtx_row_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: a fast instance (CLK_DIV=1, DWELL=4)
// for frame content and a default instance for protocol timing.
module tb_led_matrix_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] note_R = '0;
  logic [9:0] note_B = '0;
  logic [2:0] offset = '0;
  logic       finish = 1'b0;

  logic       f_sclk, f_sdata, f_latch, f_oe_n, f_fd;
  logic [2:0] f_row;
  logic       d_sclk, d_sdata, d_latch, d_oe_n, d_fd;
  logic [2:0] d_row;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_matrix_scan #(
    .ROWS(8), .COLS(10), .CLK_DIV(1), .DWELL(4), .SHOW_JUDGE(1)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .note_R(note_R), .note_B(note_B),
    .offset(offset), .finish(finish),
    .mtx_sclk(f_sclk), .mtx_sdata(f_sdata), .mtx_latch(f_latch),
    .mtx_oe_n(f_oe_n), .mtx_row(f_row), .frame_done(f_fd)
  );

  led_matrix_scan #(
    .ROWS(8), .COLS(10), .CLK_DIV(4), .DWELL(2000), .SHOW_JUDGE(1)
  ) u_dflt (
    .clk(clk), .rst_n(rst_n), .note_R(note_R), .note_B(note_B),
    .offset(offset), .finish(finish),
    .mtx_sclk(d_sclk), .mtx_sdata(d_sdata), .mtx_latch(d_latch),
    .mtx_oe_n(d_oe_n), .mtx_row(d_row), .frame_done(d_fd)
  );

  // Fast instance: reassemble shifted words per row, snapshot on frame_done.
  logic [19:0] sh;
  int          bitcnt;
  logic        p_sclk, p_latch;
  logic [19:0] rowword [8];
  logic [19:0] fwords  [8];
  int          rowbits [8];
  int          fbits   [8];
  int          fcnt = 0, fcyc = 0, fperiod = 0;
  logic        got_first;
  logic [2:0]  first_row;

  always @(negedge clk) begin
    if (!rst_n) begin
      sh        <= '0;
      bitcnt    <= 0;
      p_sclk    <= 1'b0;
      p_latch   <= 1'b0;
      got_first <= 1'b0;
      first_row <= 3'd7;
      for (int i = 0; i < 8; i++) begin
        rowword[i] <= '0;
        rowbits[i] <= 0;
      end
    end else begin
      if (f_sclk && !p_sclk) begin
        sh     <= {sh[18:0], f_sdata};
        bitcnt <= bitcnt + 1;
      end
      if (f_latch && !p_latch) begin
        rowword[f_row] <= sh;
        rowbits[f_row] <= bitcnt;
        bitcnt         <= 0;
        if (!got_first) begin
          got_first <= 1'b1;
          first_row <= f_row;
        end
      end
      if (f_fd) begin
        fwords  <= rowword;
        fbits   <= rowbits;
        fperiod <= cyc - fcyc;
        fcyc    <= cyc;
        fcnt    <= fcnt + 1;
      end
      p_sclk  <= f_sclk;
      p_latch <= f_latch;
    end
  end

  // Default instance: protocol statistics, copied the cycle after frame_done.
  logic dp_sclk, dp_latch, dp_oe_n, dp_sdata, dp_fd;
  int d_stab, d_rise, d_lat_len, d_oe_len;
  int d_min_stab, d_min_rise, d_max_rise, d_min_lat, d_max_lat, d_min_oe, d_max_oe, d_ovl;
  int df_min_stab, df_min_rise, df_max_rise, df_min_lat, df_max_lat, df_min_oe, df_max_oe, df_ovl;
  int dfcnt = 0, dfcyc = 0, dfperiod = 0;
  localparam int BIG = 1 << 30;

  always @(negedge clk) begin
    if (!rst_n) begin
      dp_sclk <= 1'b0; dp_latch <= 1'b0; dp_oe_n <= 1'b1; dp_sdata <= 1'b0; dp_fd <= 1'b0;
      d_stab <= 0; d_rise <= 0; d_lat_len <= 0; d_oe_len <= 0;
      d_min_stab <= BIG; d_min_rise <= BIG; d_max_rise <= 0;
      d_min_lat <= BIG; d_max_lat <= 0; d_min_oe <= BIG; d_max_oe <= 0; d_ovl <= 0;
    end else if (dp_fd) begin
      df_min_stab <= d_min_stab; df_min_rise <= d_min_rise; df_max_rise <= d_max_rise;
      df_min_lat <= d_min_lat; df_max_lat <= d_max_lat;
      df_min_oe <= d_min_oe; df_max_oe <= d_max_oe; df_ovl <= d_ovl;
      dfperiod <= cyc - dfcyc;
      dfcyc    <= cyc;
      dfcnt    <= dfcnt + 1;
      d_min_stab <= BIG; d_min_rise <= BIG; d_max_rise <= 0;
      d_min_lat <= BIG; d_max_lat <= 0; d_min_oe <= BIG; d_max_oe <= 0; d_ovl <= 0;
      d_stab <= 0;
      dp_sclk <= d_sclk; dp_latch <= d_latch; dp_oe_n <= d_oe_n; dp_sdata <= d_sdata; dp_fd <= d_fd;
    end else begin
      d_stab <= (d_sdata == dp_sdata) ? d_stab + 1 : 0;
      if (d_sclk && !dp_sclk) begin
        d_rise <= d_rise + 1;
        if (d_sdata != dp_sdata) d_min_stab <= 0;
        else if (d_stab + 1 < d_min_stab) d_min_stab <= d_stab + 1;
      end
      if (d_latch && !dp_latch) begin
        if (d_rise < d_min_rise) d_min_rise <= d_rise;
        if (d_rise > d_max_rise) d_max_rise <= d_rise;
        d_rise <= 0;
      end
      d_lat_len <= d_latch ? d_lat_len + 1 : 0;
      if (!d_latch && dp_latch) begin
        if (d_lat_len < d_min_lat) d_min_lat <= d_lat_len;
        if (d_lat_len > d_max_lat) d_max_lat <= d_lat_len;
      end
      d_oe_len <= !d_oe_n ? d_oe_len + 1 : 0;
      if (d_oe_n && !dp_oe_n) begin
        if (d_oe_len < d_min_oe) d_min_oe <= d_oe_len;
        if (d_oe_len > d_max_oe) d_max_oe <= d_oe_len;
      end
      if ((!d_oe_n || d_latch) && d_sclk) d_ovl <= d_ovl + 1;
      dp_sclk <= d_sclk; dp_latch <= d_latch; dp_oe_n <= d_oe_n; dp_sdata <= d_sdata; dp_fd <= d_fd;
    end
  end

  // Returns in the SNAP cycle that follows a fast-instance frame_done.
  task automatic wait_frame();
    int start;
    bit seen;
    start = fcnt;
    seen  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (fcnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      $display("FAIL frame_timeout: no frame_done within 1000 cycles, required one");
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    note_R = 10'h201;
    note_B = 10'h000;
    offset = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    total++; if (f_sclk !== 1'b0)  $display("FAIL rst_sclk: got %b want 0", f_sclk);  else passed++;
    total++; if (f_sdata !== 1'b0) $display("FAIL rst_sdata: got %b want 0", f_sdata); else passed++;
    total++; if (f_latch !== 1'b0) $display("FAIL rst_latch: got %b want 0", f_latch); else passed++;
    total++; if (f_oe_n !== 1'b1)  $display("FAIL rst_oe_n: got %b want 1", f_oe_n);   else passed++;
    total++; if (f_row !== 3'd0)   $display("FAIL rst_row: got %0d want 0", f_row);    else passed++;
    total++; if (f_fd !== 1'b0)    $display("FAIL rst_frame_done: got %b want 0", f_fd); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_row_words();
    logic [19:0] exp;
    wait_frame();
    for (int r = 0; r < 8; r++) begin
      exp = (r == 2) ? 20'h80400 : (r == 7) ? 20'hFFFFF : 20'h00000;
      total++;
      if (fwords[r] !== exp) $display("FAIL row_word[%0d]: got %h want %h", r, fwords[r], exp);
      else passed++;
      total++;
      if (fbits[r] !== 20) $display("FAIL row_bits[%0d]: got %0d want 20", r, fbits[r]);
      else passed++;
    end
    wait_frame();
    total++;
    if (fperiod !== 377) $display("FAIL frame_period_fast: got %0d want 377", fperiod);
    else passed++;
  endtask

  task automatic test_midframe_change();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (f_row == 3'd3 && !f_oe_n) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) $display("FAIL midframe_row3: row 3 display not reached in 500 cycles");
    else passed++;
    note_R = 10'h0F0;
    wait_frame();
    total++;
    if (fwords[2] !== 20'h80400) $display("FAIL midframe_torn: row2 got %h want 80400", fwords[2]);
    else passed++;
    total++;
    if (fwords[3] !== 20'h00000) $display("FAIL midframe_row3_word: got %h want 00000", fwords[3]);
    else passed++;
    wait_frame();
    total++;
    if (fwords[2] !== 20'h3C000) $display("FAIL midframe_next: row2 got %h want 3c000", fwords[2]);
    else passed++;
  endtask

  task automatic test_offset();
    logic [19:0] exp;
    note_R = 10'h000;
    note_B = 10'h3FF;
    offset = 3'd7;
    wait_frame();
    for (int r = 0; r < 8; r++) begin
      exp = (r == 7) ? 20'hFFFFF : 20'h00000;
      total++;
      if (fwords[r] !== exp) $display("FAIL offset7_row[%0d]: got %h want %h", r, fwords[r], exp);
      else passed++;
    end
    offset = 3'd0;
    wait_frame();
    total++;
    if (fwords[0] !== 20'h003FF) $display("FAIL offset0_blue: row0 got %h want 003ff", fwords[0]);
    else passed++;
  endtask

  task automatic test_finish();
    logic [19:0] exp;
    note_R = 10'h3FF;
    note_B = 10'h000;
    offset = 3'd2;
    repeat (50) @(posedge clk);
    #1 finish = 1'b1;
    @(posedge clk);
    #1 finish = 1'b0;
    wait_frame();
    total++;
    if (fwords[2] !== 20'hFFC00) $display("FAIL finish_before: row2 got %h want ffc00", fwords[2]);
    else passed++;
    wait_frame();
    for (int r = 0; r < 8; r++) begin
      exp = (r == 7) ? 20'hFFFFF : 20'h00000;
      total++;
      if (fwords[r] !== exp) $display("FAIL finish_blank_row[%0d]: got %h want %h", r, fwords[r], exp);
      else passed++;
    end
    wait_frame();
    total++;
    if (fwords[2] !== 20'hFFC00) $display("FAIL finish_after: row2 got %h want ffc00", fwords[2]);
    else passed++;
  endtask

  // Entered in a SNAP cycle: the pulse coincides with the capture.
  task automatic test_finish_at_snap();
    finish = 1'b1;
    @(posedge clk);
    #1 finish = 1'b0;
    wait_frame();
    total++;
    if (fwords[2] !== 20'hFFC00) $display("FAIL snapfin_live: row2 got %h want ffc00", fwords[2]);
    else passed++;
    wait_frame();
    total++;
    if (fwords[2] !== 20'h00000) $display("FAIL snapfin_blank: row2 got %h want 00000", fwords[2]);
    else passed++;
    total++;
    if (fwords[7] !== 20'hFFFFF) $display("FAIL snapfin_judge: row7 got %h want fffff", fwords[7]);
    else passed++;
    wait_frame();
    total++;
    if (fwords[2] !== 20'hFFC00) $display("FAIL snapfin_restore: row2 got %h want ffc00", fwords[2]);
    else passed++;
  endtask

  task automatic test_protocol();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk); #1;
      if (dfcnt >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) $display("FAIL proto_timeout: default frames got %0d want 2", dfcnt);
    else passed++;
    total++; if (df_min_rise !== 20) $display("FAIL proto_min_rises: got %0d want 20", df_min_rise); else passed++;
    total++; if (df_max_rise !== 20) $display("FAIL proto_max_rises: got %0d want 20", df_max_rise); else passed++;
    total++; if (df_min_stab < 4) $display("FAIL proto_setup: got %0d want >=4", df_min_stab); else passed++;
    total++; if (df_min_lat !== 4) $display("FAIL proto_latch_min: got %0d want 4", df_min_lat); else passed++;
    total++; if (df_max_lat !== 4) $display("FAIL proto_latch_max: got %0d want 4", df_max_lat); else passed++;
    total++; if (df_min_oe !== 2000) $display("FAIL proto_oe_min: got %0d want 2000", df_min_oe); else passed++;
    total++; if (df_max_oe !== 2000) $display("FAIL proto_oe_max: got %0d want 2000", df_max_oe); else passed++;
    total++; if (df_ovl !== 0) $display("FAIL proto_overlap: got %0d want 0", df_ovl); else passed++;
    total++; if (dfperiod !== 17329) $display("FAIL proto_period: got %0d want 17329", dfperiod); else passed++;
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (f_sclk) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) $display("FAIL midrst_shift: sclk high not seen in 1000 cycles");
    else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (f_sclk !== 1'b0)  $display("FAIL midrst_sclk: got %b want 0", f_sclk);  else passed++;
    total++; if (f_sdata !== 1'b0) $display("FAIL midrst_sdata: got %b want 0", f_sdata); else passed++;
    total++; if (f_latch !== 1'b0) $display("FAIL midrst_latch: got %b want 0", f_latch); else passed++;
    total++; if (f_oe_n !== 1'b1)  $display("FAIL midrst_oe_n: got %b want 1", f_oe_n);   else passed++;
    total++; if (f_row !== 3'd0)   $display("FAIL midrst_row: got %0d want 0", f_row);    else passed++;
    total++; if (d_oe_n !== 1'b1)  $display("FAIL midrst_dflt_oe_n: got %b want 1", d_oe_n); else passed++;
    note_R = 10'h001;
    note_B = 10'h000;
    offset = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_frame();
    total++;
    if (first_row !== 3'd0) $display("FAIL midrst_first_row: got %0d want 0", first_row);
    else passed++;
    total++;
    if (fwords[0] !== 20'h00400) $display("FAIL midrst_fresh_snap: row0 got %h want 00400", fwords[0]);
    else passed++;
    total++;
    if (fwords[2] !== 20'h00000) $display("FAIL midrst_row2: got %h want 00000", fwords[2]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_row_words();
    test_midframe_change();
    test_offset();
    test_finish();
    test_finish_at_snap();
    test_protocol();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
